ct_spsram_1024x128_arb: RTL

CT_SPSRAM_1024X128_ARB -- requirements
Module: ct_spsram_1024x128_arb

---
 rtl/ct_spsram_1024x128_arb.sv | 79 +++++++
 1 files changed

// File: rtl/ct_spsram_1024x128_arb.sv
// ct_spsram_1024x128_arb: zero-fills a 1024x128 single-port SRAM after reset,
// then round-robin arbitrates two request ports onto it.
module ct_spsram_1024x128_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  p0_req_vld,
    input  logic                  p0_req_wr,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    input  logic [DATA_WIDTH-1:0] p0_req_bwe,
    output logic                  p0_req_gnt,
    input  logic                  p1_req_vld,
    input  logic                  p1_req_wr,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    input  logic [DATA_WIDTH-1:0] p1_req_bwe,
    output logic                  p1_req_gnt,
    output logic                  rd_data_vld,
    output logic                  rd_data_port,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    typedef enum logic {INIT, RUN} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  rr_ptr;
    logic                  gnt, gnt_wr;
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state        <= INIT;
            cnt          <= '0;
            rr_ptr       <= 1'b0;
            rd_data_vld  <= 1'b0;
            rd_data_port <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (state == INIT) cnt <= cnt + ADDR_WIDTH'(1);
            if (gnt) rr_ptr <= p0_req_gnt;
            rd_data_vld <= gnt && !gnt_wr;
            if (gnt && !gnt_wr) rd_data_port <= p1_req_gnt;
        end
    end
    assign init_done = (state == RUN);
    assign rd_data   = sram_q;
    always_comb begin
        state_nxt  = (state == INIT && cnt == '1) ? RUN : state;
        p0_req_gnt = init_done && p0_req_vld && (!p1_req_vld || !rr_ptr);
        p1_req_gnt = init_done && p1_req_vld && (!p0_req_vld || rr_ptr);
        gnt        = p0_req_gnt || p1_req_gnt;
        gnt_wr     = p1_req_gnt ? p1_req_wr : p0_req_wr;
        sram_cen   = 1'b1;
        sram_gwen  = 1'b1;
        sram_wen   = '1;
        sram_a     = '0;
        sram_d     = '0;
        // Reset gating keeps the SRAM idle even though state sits in INIT
        if (cpurst_b && state == INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt;
        end else if (gnt) begin
            sram_cen  = 1'b0;
            sram_gwen = !gnt_wr;
            sram_a    = p1_req_gnt ? p1_req_addr : p0_req_addr;
            sram_wen  = gnt_wr ? ~(p1_req_gnt ? p1_req_bwe : p0_req_bwe) : '1;
            sram_d    = gnt_wr ? (p1_req_gnt ? p1_req_wdata : p0_req_wdata) : '0;
        end
    end
endmodule
